mux_seq: RTL and testbench
==========================

# mux_seq

Parametrised, registered N-channel W-bit multiplexer with a manual select load and an auto-scan mode that steps through channels every DWELL cycles. It succeeds the fixed 4:1 combinational mux for datapaths that need more channels, wider data, a registered output and a deterministic settling flag. It sits between the channel sources and a single downstream consumer that samples `dout` only when `dout_valid` is high.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `NCH`, 4, number of channels (≥2)
- `SELW`, `$clog2(NCH)`, select width (derived; do not override)
- `DWELL`, 4, cycles per channel in auto-scan (≥1)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `din`  in  NCH*WIDTH  packed channels; channel k = `din[k*WIDTH +: WIDTH]`
- `sel_in`  in  SELW  manual select value
- `sel_load`  in  1  load `sel_in` into `sel_cur` at next edge
- `auto_en`  in  1  enable auto-scan stepping
- `dout`  out  WIDTH  registered selected channel
- `dout_valid`  out  1  `dout` reflects `sel_cur`
- `sel_cur`  out  SELW  current channel
- `wrap`  out  1  one-cycle pulse when auto-scan wraps NCH-1 → 0
- `sel_err`  out  1  one-cycle pulse when `sel_load` carries `sel_in` ≥ NCH

## Operation
- Registers: `sel_cur`, `dwell_cnt` (0..DWELL-1), `dout`, `dout_valid`, `wrap`, `sel_err`.
- Every edge: `dout` ← channel `sel_cur` (the pre-edge value).
- Select update priority per edge:
  1. `sel_load`=1, `sel_in`<NCH: `sel_cur` ← `sel_in`; `dwell_cnt` ← 0.
  2. `sel_load`=1, `sel_in`≥NCH: `sel_cur` unchanged; `sel_err` ← 1; `dwell_cnt` ← 0.
  3. `auto_en`=1, `dwell_cnt`=DWELL-1: `sel_cur` ← (`sel_cur`+1) mod NCH; `dwell_cnt` ← 0; `wrap` ← 1 iff old `sel_cur`=NCH-1.
  4. `auto_en`=1 otherwise: `dwell_cnt` ← `dwell_cnt`+1.
  5. `auto_en`=0: `dwell_cnt` ← 0; `sel_cur` holds.
- A load wins over an auto step in the same cycle, and no `wrap` pulse occurs.
- `dout_valid` ← 0 on any edge where `sel_cur` changes value, otherwise ← 1.
- Loading the value already in `sel_cur` is not a change: `dout_valid` stays 1, but `dwell_cnt` still clears.
- `wrap` and `sel_err` default to 0 on every edge where their set condition is false.
- The NCH non-power-of-2 increment wraps at NCH-1, never at 2^SELW-1.
- DWELL=1: `sel_cur` steps every cycle, so `dout_valid` stays 0 while auto-scan runs.

## Timing
- Reset, asynchronous: `dout`=0, `dout_valid`=0, `sel_cur`=0, `dwell_cnt`=0, `wrap`=0, `sel_err`=0.
- First edge after reset deassertion: `dout` = ch0, `dout_valid`=1.
- Select change latency: request at edge t.
  - Edge t: `sel_cur` = new, `dout` = old channel, `dout_valid`=0.
  - Edge t+1: `dout` = new channel, `dout_valid`=1.
- Data latency: 1 cycle from `din` to `dout` for a stable channel.
- Auto-scan period: NCH·DWELL cycles per full sweep. `wrap` asserts in the same cycle `sel_cur` returns to 0.
- Reset mid-dwell or mid-change: all state clears immediately. No pulse survives reset.

## Configuration
- `MUX_SEQ_SVA_EN` defined: concurrent assertions compile in.
  - `sel_cur` < NCH always.
  - A `sel_cur` change implies `!dout_valid` on the same cycle and `dout_valid` on the next cycle, unless another change occurs.
  - `wrap` implies `sel_cur`==0.
  - `sel_err` implies `sel_cur` is unchanged.
  - `dout`==channel `$past(sel_cur)` whenever `dout_valid`.
- `MUX_SEQ_SVA_EN` undefined: no assertions. RTL behaviour is identical.

## Test plan
- Reset release, WIDTH=8, NCH=4, `din`={8'h44,8'h33,8'h22,8'h11}, no load → `dout`=8'h11, `dout_valid`=1 one edge after release; `sel_cur`=0.
- Pulse `sel_load`, `sel_in`=2 → next edge: `sel_cur`=2, `dout_valid`=0; following edge: `dout`=8'h33, `dout_valid`=1.
- NCH=3, `sel_load`, `sel_in`=3 → `sel_err`=1 for one cycle; `sel_cur` and `dout` unchanged; `dout_valid` stays 1.
- `auto_en`=1, DWELL=4, NCH=4 from `sel_cur`=0 → `sel_cur` advances every 4 cycles as 1,2,3,0; `wrap`=1 only in the cycle `sel_cur` becomes 0 (cycle 16).
- `auto_en`=1 with `dwell_cnt`=3 and a simultaneous `sel_load` `sel_in`=1 → `sel_cur`=1, `dwell_cnt`=0, no `wrap`; next auto step occurs 4 cycles later.
- Assert `rst` mid-dwell with `sel_cur`=2 → all outputs 0 immediately (asynchronous). After release, scanning resumes from ch0 with a full DWELL before the first step.

Source files
------------

// File: rtl/mux_seq.sv
// Registered NCH:1 WIDTH-bit mux with manual select load and auto-scan (DWELL cycles/channel); MUX_SEQ_SVA_EN adds assertions.
// Latency: 1 cycle din->dout; select change shows on dout one edge after sel_cur moves (dout_valid low meanwhile).
// Backpressure: none; consumer samples dout only while dout_valid is high.
module mux_seq #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 sel_load,
    input  logic                 auto_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic [SELW-1:0]      sel_cur,
    output logic                 wrap,
    output logic                 sel_err
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_SEL = SELW'(NCH - 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);
    localparam logic [SELW:0]   NCH_EXT  = (SELW + 1)'(NCH);

    logic [CNTW-1:0]  dwell_cnt;
    logic [CNTW-1:0]  cnt_nxt;
    logic [SELW-1:0]  sel_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_dat;

    assign sel_ok = ({1'b0, sel_in} < NCH_EXT);

    // Explicit compare per channel keeps a non-power-of-2 NCH from indexing past din.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_cur == SELW'(k)) begin
                sel_dat = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        sel_nxt  = sel_cur;
        cnt_nxt  = '0;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (sel_load) begin
            if (sel_ok) begin
                sel_nxt = sel_in;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (auto_en) begin
            if (dwell_cnt == LAST_CNT) begin
                sel_nxt  = (sel_cur == LAST_SEL) ? '0 : sel_cur + SELW'(1);
                wrap_nxt = (sel_cur == LAST_SEL);
            end else begin
                cnt_nxt = dwell_cnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_cur    <= '0;
            dwell_cnt  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            sel_cur    <= sel_nxt;
            dwell_cnt  <= cnt_nxt;
            dout       <= sel_dat;
            dout_valid <= (sel_nxt == sel_cur);
            wrap       <= wrap_nxt;
            sel_err    <= err_nxt;
        end
    end

`ifdef MUX_SEQ_SVA_EN
    a_sel_range : assert property (@(posedge clk) disable iff (rst)
        {1'b0, sel_cur} < NCH_EXT);

    a_change_valid : assert property (@(posedge clk) disable iff (rst)
        (sel_cur != $past(sel_cur)) |-> !dout_valid ##1 (dout_valid || (sel_cur != $past(sel_cur))));

    a_wrap_zero : assert property (@(posedge clk) disable iff (rst)
        wrap |-> (sel_cur == '0));

    a_err_hold : assert property (@(posedge clk) disable iff (rst)
        sel_err |-> (sel_cur == $past(sel_cur)));

    a_dout_match : assert property (@(posedge clk) disable iff (rst)
        dout_valid |-> (dout == $past(sel_dat)));
`endif

endmodule

// File: tb/tb_mux_seq.sv
// Bench for mux_seq: NCH=4/DWELL=4 instance plus an NCH=3/DWELL=1 instance for the non-power-of-2 and single-cycle-dwell cases.
module tb_mux_seq;

    typedef struct {
        logic        u3;
        logic [31:0] din;
        logic        ld;
        logic [1:0]  si;
        logic        au;
        logic [1:0]  es;
        logic        ev;
        logic [7:0]  ed;
        logic        ew;
        logic        ee;
    } vec_t;

    logic        clk;
    logic        rst;

    logic [31:0] din;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic        auto_en;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [1:0]  sel_cur;
    logic        wrap;
    logic        sel_err;

    logic [23:0] din3;
    logic [1:0]  sel_in3;
    logic        sel_load3;
    logic        auto3;
    logic [7:0]  dout3;
    logic        dout_valid3;
    logic [1:0]  sel_cur3;
    logic        wrap3;
    logic        sel_err3;

    int n_vec = 0;
    int n_err = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t tab_c[$];
    vec_t sb[$];

    localparam logic [31:0] D4  = 32'h44332211;
    localparam logic [31:0] D4X = 32'h4433225a;
    localparam logic [31:0] D3  = 32'h00ccbbaa;

    mux_seq #(.WIDTH(8), .NCH(4), .DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .sel_in(sel_in), .sel_load(sel_load),
        .auto_en(auto_en), .dout(dout), .dout_valid(dout_valid), .sel_cur(sel_cur),
        .wrap(wrap), .sel_err(sel_err)
    );

    mux_seq #(.WIDTH(8), .NCH(3), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .sel_in(sel_in3), .sel_load(sel_load3),
        .auto_en(auto3), .dout(dout3), .dout_valid(dout_valid3), .sel_cur(sel_cur3),
        .wrap(wrap3), .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic u3, input logic [31:0] d, input logic ld,
                                input logic [1:0] si, input logic au, input logic [1:0] es,
                                input logic ev, input logic [7:0] ed, input logic ew,
                                input logic ee);
        vec_t v;
        v.u3 = u3; v.din = d; v.ld = ld; v.si = si; v.au = au;
        v.es = es; v.ev = ev; v.ed = ed; v.ew = ew; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, score just after the rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        if (v.u3) begin
            din3 = v.din[23:0]; sel_load3 = v.ld; sel_in3 = v.si; auto3 = v.au;
        end else begin
            din = v.din; sel_load = v.ld; sel_in = v.si; auto_en = v.au;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.u3) begin
            chk("sel_cur3", idx, {30'd0, sel_cur3}, {30'd0, e.es});
            chk("dout_valid3", idx, {31'd0, dout_valid3}, {31'd0, e.ev});
            chk("dout3", idx, {24'd0, dout3}, {24'd0, e.ed});
            chk("wrap3", idx, {31'd0, wrap3}, {31'd0, e.ew});
            chk("sel_err3", idx, {31'd0, sel_err3}, {31'd0, e.ee});
        end else begin
            chk("sel_cur", idx, {30'd0, sel_cur}, {30'd0, e.es});
            chk("dout_valid", idx, {31'd0, dout_valid}, {31'd0, e.ev});
            chk("dout", idx, {24'd0, dout}, {24'd0, e.ed});
            chk("wrap", idx, {31'd0, wrap}, {31'd0, e.ew});
            chk("sel_err", idx, {31'd0, sel_err}, {31'd0, e.ee});
        end
        @(negedge clk);
    endtask

    task automatic rst_chk(input int tag);
        chk("rst_dout", tag, {24'd0, dout}, 32'd0);
        chk("rst_valid", tag, {31'd0, dout_valid}, 32'd0);
        chk("rst_sel", tag, {30'd0, sel_cur}, 32'd0);
        chk("rst_wrap", tag, {31'd0, wrap}, 32'd0);
        chk("rst_err", tag, {31'd0, sel_err}, 32'd0);
        chk("rst_dout3", tag, {24'd0, dout3}, 32'd0);
        chk("rst_valid3", tag, {31'd0, dout_valid3}, 32'd0);
        chk("rst_sel3", tag, {30'd0, sel_cur3}, 32'd0);
        chk("rst_wrap3", tag, {31'd0, wrap3}, 32'd0);
        chk("rst_err3", tag, {31'd0, sel_err3}, 32'd0);
    endtask

    initial begin
        // Manual loads, full auto sweep, load-over-step, data latency.
        tab_a.push_back(mk(0, D4, 0, 0, 0, 0, 1, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 2, 0, 2, 0, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 0, 2, 1, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 2, 0, 2, 1, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 0, 0, 0, 0, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 0, 0, 1, 8'h11, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 0, 1, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 1, 0, 8'h11, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 1, 1, 8'h22, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 0, 8'h22, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 1, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 3, 0, 8'h33, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 3, 1, 8'h44, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 0, 0, 8'h44, 1, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 0, 1, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 1, 1, 1, 0, 8'h11, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 1, 1, 8'h22, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 0, 8'h22, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 1, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 3, 0, 8'h33, 0, 0));
        for (int i = 0; i < 3; i++) tab_a.push_back(mk(0, D4, 0, 0, 1, 3, 1, 8'h44, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 0, 1, 0, 0, 8'h44, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 0, 0, 1, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4X, 0, 0, 0, 0, 1, 8'h5a, 0, 0));
        tab_a.push_back(mk(0, D4, 1, 2, 0, 2, 0, 8'h11, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 1, 8'h33, 0, 0));
        tab_a.push_back(mk(0, D4, 0, 0, 1, 2, 1, 8'h33, 0, 0));

        // After a mid-dwell reset: full dwell on ch0 before the first step.
        for (int i = 0; i < 3; i++) tab_b.push_back(mk(0, D4, 0, 0, 1, 0, 1, 8'h11, 0, 0));
        tab_b.push_back(mk(0, D4, 0, 0, 1, 1, 0, 8'h11, 0, 0));
        tab_b.push_back(mk(0, D4, 0, 0, 1, 1, 1, 8'h22, 0, 0));
        tab_b.push_back(mk(0, D4, 0, 0, 0, 1, 1, 8'h22, 0, 0));

        // NCH=3, DWELL=1: out-of-range load, wrap at 2, valid low while scanning.
        tab_c.push_back(mk(1, D3, 0, 0, 0, 0, 1, 8'haa, 0, 0));
        tab_c.push_back(mk(1, D3, 1, 3, 0, 0, 1, 8'haa, 0, 1));
        tab_c.push_back(mk(1, D3, 0, 0, 0, 0, 1, 8'haa, 0, 0));
        tab_c.push_back(mk(1, D3, 0, 0, 1, 1, 0, 8'haa, 0, 0));
        tab_c.push_back(mk(1, D3, 0, 0, 1, 2, 0, 8'hbb, 0, 0));
        tab_c.push_back(mk(1, D3, 0, 0, 1, 0, 0, 8'hcc, 1, 0));
        tab_c.push_back(mk(1, D3, 0, 0, 1, 1, 0, 8'haa, 0, 0));
        tab_c.push_back(mk(1, D3, 0, 0, 0, 1, 1, 8'hbb, 0, 0));
        tab_c.push_back(mk(1, D3, 1, 1, 0, 1, 1, 8'hbb, 0, 0));

        rst = 1'b0;
        din = D4; sel_in = '0; sel_load = 1'b0; auto_en = 1'b0;
        din3 = D3[23:0]; sel_in3 = '0; sel_load3 = 1'b0; auto3 = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst_chk(0);
        rst = 1'b0;

        foreach (tab_a[i]) run_vec(tab_a[i], i);

        // Asynchronous reset in the middle of a dwell on ch2.
        rst = 1'b1;
        #1;
        rst_chk(1);
        @(negedge clk);
        rst_chk(2);
        rst = 1'b0;

        foreach (tab_b[i]) run_vec(tab_b[i], 100 + i);
        foreach (tab_c[i]) run_vec(tab_c[i], 200 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
